// File: rtl/sync_data_qualify.sv
// rtl/sync_data_qualify.sv - stability qualifier for a synchronized multi-bit bus with glitch counter
module sync_data_qualify #(
    parameter int unsigned       WIDTH         = 1,
    parameter int unsigned       STABLE_CYCLES = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE   = {WIDTH{1'b0}},
    parameter int unsigned       CNT_WIDTH     = 16
) (
    input  logic                 dest_clk,
    input  logic                 dest_rst_n,
    input  logic [WIDTH-1:0]     sync_in,
    input  logic                 glitch_clear,
    output logic [WIDTH-1:0]     data_out,
    output logic                 data_changed,
    output logic                 stable,
    output logic [CNT_WIDTH-1:0] glitch_count
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_ONE = SW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [WIDTH-1:0]     cand_q, cand_d;
    logic [SW-1:0]        stab_cnt_q, stab_cnt_d;
    logic [WIDTH-1:0]     data_out_q, data_out_d;
    logic                 data_changed_q, data_changed_d;
    logic                 stable_q, stable_d;
    logic [CNT_WIDTH-1:0] glitch_count_q, glitch_count_d;
    logic                 glitch_event;
    logic                 qualify;

    // Track the candidate, decide qualification and count abandoned candidates.
    always_comb begin
        cand_d         = cand_q;
        stab_cnt_d     = stab_cnt_q;
        data_out_d     = data_out_q;
        data_changed_d = 1'b0;
        glitch_count_d = glitch_count_q;

        if (sync_in != cand_q) begin
            cand_d     = sync_in;
            stab_cnt_d = STAB_ONE;
        end else if (stab_cnt_q < STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + STAB_ONE;
        end

        // An unqualified candidate that differs from data_out is being abandoned;
        // falling back to data_out's value is not a transient.
        glitch_event = (sync_in != cand_q) && (stab_cnt_q < STAB_MAX) &&
                       (cand_q != data_out_q);

        qualify = (stab_cnt_d == STAB_MAX) && (cand_d != data_out_q);
        if (qualify) begin
            data_out_d     = cand_d;
            data_changed_d = 1'b1;
        end

        stable_d = (stab_cnt_d == STAB_MAX);

        // Clear wins over the old count but never swallows a same-cycle event.
        if (glitch_clear) begin
            glitch_count_d = glitch_event ? CNT_ONE : '0;
        end else if (glitch_event && (glitch_count_q != {CNT_WIDTH{1'b1}})) begin
            glitch_count_d = glitch_count_q + CNT_ONE;
        end
    end

    // State registers; reset discards any in-progress candidate and reports stable.
    always_ff @(posedge dest_clk) begin
        if (!dest_rst_n) begin
            cand_q         <= RESET_VALUE;
            stab_cnt_q     <= STAB_MAX;
            data_out_q     <= RESET_VALUE;
            data_changed_q <= 1'b0;
            stable_q       <= 1'b1;
            glitch_count_q <= '0;
        end else begin
            cand_q         <= cand_d;
            stab_cnt_q     <= stab_cnt_d;
            data_out_q     <= data_out_d;
            data_changed_q <= data_changed_d;
            stable_q       <= stable_d;
            glitch_count_q <= glitch_count_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_changed = data_changed_q;
    assign stable       = stable_q;
    assign glitch_count = glitch_count_q;

endmodule

// File: tb/tb_sync_data_qualify.sv
// tb/tb_sync_data_qualify.sv - directed self-checking bench for sync_data_qualify
module tb_sync_data_qualify;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // DUT A: WIDTH=8, STABLE_CYCLES=4, CNT_WIDTH=16
    logic [7:0]  a_in = 8'h00;
    logic        a_clr = 1'b0;
    logic [7:0]  a_out;
    logic        a_chg, a_stable;
    logic [15:0] a_gc;

    // DUT B: WIDTH=8, STABLE_CYCLES=4, CNT_WIDTH=2
    logic [7:0]  b_in = 8'h00;
    logic        b_clr = 1'b0;
    logic [7:0]  b_out;
    logic        b_chg, b_stable;
    logic [1:0]  b_gc;

    // DUT C: WIDTH=8, STABLE_CYCLES=1, CNT_WIDTH=16
    logic [7:0]  c_in = 8'h00;
    logic        c_clr = 1'b0;
    logic [7:0]  c_out;
    logic        c_chg, c_stable;
    logic [15:0] c_gc;

    int tests_run = 0;
    int tests_failed = 0;

    sync_data_qualify #(.WIDTH(8), .STABLE_CYCLES(4), .CNT_WIDTH(16)) u_a (
        .dest_clk(clk), .dest_rst_n(rst_n), .sync_in(a_in), .glitch_clear(a_clr),
        .data_out(a_out), .data_changed(a_chg), .stable(a_stable), .glitch_count(a_gc)
    );

    sync_data_qualify #(.WIDTH(8), .STABLE_CYCLES(4), .CNT_WIDTH(2)) u_b (
        .dest_clk(clk), .dest_rst_n(rst_n), .sync_in(b_in), .glitch_clear(b_clr),
        .data_out(b_out), .data_changed(b_chg), .stable(b_stable), .glitch_count(b_gc)
    );

    sync_data_qualify #(.WIDTH(8), .STABLE_CYCLES(1), .CNT_WIDTH(16)) u_c (
        .dest_clk(clk), .dest_rst_n(rst_n), .sync_in(c_in), .glitch_clear(c_clr),
        .data_out(c_out), .data_changed(c_chg), .stable(c_stable), .glitch_count(c_gc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_in = 8'h00; b_in = 8'h00; c_in = 8'h00;
        a_clr = 1'b0; b_clr = 1'b0; c_clr = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in = 8'hFF;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (a_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data_out got %h want 00", a_out); end
        tests_run++;
        if (a_stable !== 1'b1) begin tests_failed++; $display("FAIL reset_stable got %b want 1", a_stable); end
        tests_run++;
        if (a_chg !== 1'b0) begin tests_failed++; $display("FAIL reset_changed got %b want 0", a_chg); end
        tests_run++;
        if (a_gc !== 16'd0) begin tests_failed++; $display("FAIL reset_glitch_count got %0d want 0", a_gc); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (a_out !== 8'h00) begin tests_failed++; $display("FAIL reset_release_early got %h want 00", a_out); end
        step();
        tests_run++;
        if (a_out !== 8'hFF || a_chg !== 1'b1) begin
            tests_failed++; $display("FAIL reset_release_qualify got %h/%b want ff/1", a_out, a_chg);
        end
    endtask

    task automatic test_clean_update();
        int stable_low;
        int pulses;
        int qual_step;
        do_reset();
        stable_low = 0; pulses = 0; qual_step = -1;
        a_in = 8'hA5;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (a_stable === 1'b0) stable_low++;
            if (a_chg === 1'b1) pulses++;
            if (qual_step < 0 && a_out === 8'hA5) qual_step = i;
        end
        tests_run++;
        if (stable_low != 3) begin tests_failed++; $display("FAIL clean_stable_low got %0d want 3", stable_low); end
        tests_run++;
        if (qual_step != 4) begin tests_failed++; $display("FAIL clean_qualify_edge got %0d want 4", qual_step); end
        tests_run++;
        if (pulses != 1) begin tests_failed++; $display("FAIL clean_pulses got %0d want 1", pulses); end
        tests_run++;
        if (a_gc !== 16'd0) begin tests_failed++; $display("FAIL clean_glitch_count got %0d want 0", a_gc); end
    endtask

    task automatic test_transient();
        int pulses;
        do_reset();
        pulses = 0;
        a_in = 8'hA5;
        for (int i = 0; i < 2; i++) begin step(); if (a_chg === 1'b1) pulses++; end
        a_in = 8'h00;
        for (int i = 0; i < 6; i++) begin step(); if (a_chg === 1'b1) pulses++; end
        tests_run++;
        if (a_out !== 8'h00 || pulses != 0) begin
            tests_failed++; $display("FAIL transient_hold got %h/%0d pulses want 00/0", a_out, pulses);
        end
        tests_run++;
        if (a_gc !== 16'd1) begin tests_failed++; $display("FAIL transient_count got %0d want 1", a_gc); end

        do_reset();
        a_in = 8'h11;
        step();
        a_in = 8'h22;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (a_out !== 8'h00) begin tests_failed++; $display("FAIL rollover_early got %h want 00", a_out); end
        step();
        tests_run++;
        if (a_out !== 8'h22 || a_chg !== 1'b1) begin
            tests_failed++; $display("FAIL rollover_qualify got %h/%b want 22/1", a_out, a_chg);
        end
        tests_run++;
        if (a_gc !== 16'd1) begin tests_failed++; $display("FAIL rollover_count got %0d want 1", a_gc); end
    endtask

    task automatic test_saturation_clear();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b_in = 8'h11; step();
            b_in = 8'h00; step();
        end
        tests_run++;
        if (b_gc !== 2'd3) begin tests_failed++; $display("FAIL sat_count got %0d want 3", b_gc); end
        b_clr = 1'b1; step(); b_clr = 1'b0;
        tests_run++;
        if (b_gc !== 2'd0) begin tests_failed++; $display("FAIL clear_alone got %0d want 0", b_gc); end
        b_in = 8'h11; step();
        b_in = 8'h00; b_clr = 1'b1; step(); b_clr = 1'b0;
        tests_run++;
        if (b_gc !== 2'd1) begin tests_failed++; $display("FAIL clear_with_event got %0d want 1", b_gc); end
        tests_run++;
        if (b_out !== 8'h00) begin tests_failed++; $display("FAIL sat_data_out got %h want 00", b_out); end
    endtask

    task automatic test_reset_mid_settle();
        do_reset();
        a_in = 8'h5A;
        for (int i = 0; i < 2; i++) step();
        rst_n = 1'b0;
        step();
        tests_run++;
        if (a_out !== 8'h00 || a_stable !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_state got %h/%b want 00/1", a_out, a_stable);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (a_out !== 8'h00 || a_stable !== 1'b0) begin
            tests_failed++; $display("FAIL midreset_fresh got %h/%b want 00/0", a_out, a_stable);
        end
        step();
        tests_run++;
        if (a_out !== 8'h5A || a_chg !== 1'b1) begin
            tests_failed++; $display("FAIL midreset_qualify got %h/%b want 5a/1", a_out, a_chg);
        end
        tests_run++;
        if (a_gc !== 16'd0) begin tests_failed++; $display("FAIL midreset_count got %0d want 0", a_gc); end
    endtask

    task automatic test_stable_one();
        logic [7:0] exp_out;
        logic [7:0] v;
        logic       exp_chg;
        do_reset();
        exp_out = 8'h00;
        for (int i = 0; i < 100; i++) begin
            v = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) v = exp_out;
            c_in = v;
            step();
            exp_chg = (v != exp_out);
            exp_out = v;
            tests_run++;
            if (c_out !== exp_out || c_chg !== exp_chg) begin
                tests_failed++;
                $display("FAIL s1_cycle%0d got %h/%b want %h/%b", i, c_out, c_chg, exp_out, exp_chg);
            end
        end
        tests_run++;
        if (c_gc !== 16'd0) begin tests_failed++; $display("FAIL s1_count got %0d want 0", c_gc); end
    endtask

    initial begin
        test_reset();
        test_clean_update();
        test_transient();
        test_saturation_clear();
        test_reset_mid_settle();
        test_stable_one();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
